permute_dump_control: RTL and testbench
=======================================

# permute_dump_control

Sequencing FSM for the Keccak permute/dump datapath. It accepts rate blocks from the padding/absorb stage over a valid/ready handshake and clears the datapath at message start. It runs 24-round permutations with absorption on the first round, then loads the PISO output buffer and dumps words downstream. Squeeze permutations repeat until the requested output size is reached.

## Interface

Parameters
- ROUNDS, 24: Keccak-f rounds per permutation.
- W, 64: output word width. Informational only; no width in this block depends on it.

Ports
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- src_valid  in  1  rate block, mode and output size are valid at the datapath inputs. Must stay high until accepted.
- src_last  in  1  current rate block is the last block of the message. Qualified by src_valid.
- src_ready  out  1  block accepted this cycle when src_valid & src_ready.
- dout_valid  out  1  data_out word valid.
- dout_ready  in  1  downstream accepts the word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final output word transfers.
- datapath_clear  out  1  one-cycle synchronous clear, ORed with rst at the datapath rst pin.
- copy_control_regs_en, absorb_enable, round_en, round_count_load  out  1 each  datapath permute controls.
- output_buffer_we, output_buffer_shift_en, output_counter_load, output_counter_rst  out  1 each  datapath dump controls.
- round_done, output_buffer_empty, last_output_block, output_size_reached  in  1 each  datapath status.

## Operation

- States: IDLE, CLEAR, ABSORB_FIRST, PERMUTE, ABSORB_NEXT, LOAD_BUF, DUMP, SQUEEZE, DONE.
- All datapath controls are 0 unless listed for a state.
- IDLE: src_ready=0. If src_valid is high, go to CLEAR.
- CLEAR: datapath_clear=1, output_counter_rst=1, round_count_load=1. Go to ABSORB_FIRST.
- ABSORB_FIRST: src_ready=1.
  - On handshake: copy_control_regs_en=1, absorb_enable=1, round_en=1 in the same cycle. The datapath mode passthrough needs this. Capture src_last into last_q. Go to PERMUTE.
  - Without a handshake: stay.
- PERMUTE: round_en=1.
  - When round_done=1 (the final round): round_count_load=1. The datapath counter gives load priority over count.
  - On that final round, go to LOAD_BUF if last_q=1, otherwise to ABSORB_NEXT.
- ABSORB_NEXT: src_ready=1. On handshake: absorb_enable=1, round_en=1, capture src_last into last_q, go to PERMUTE.
- LOAD_BUF: output_buffer_we=1, output_counter_load=1. Go to DUMP.
- DUMP: dout_valid=1, output_buffer_shift_en=dout_ready. On a shift:
  - output_size_reached=1 → DONE. This has priority over output_buffer_empty.
  - Otherwise output_buffer_empty=1 → SQUEEZE.
  - Otherwise stay in DUMP.
- SQUEEZE: round_en=1, absorb_enable=0. On round_done: round_count_load=1, go to LOAD_BUF.
- DONE: done=1. Go to IDLE.
- Permutation length:
  - The absorb cycle counts as round 0, so the absorb cycle plus PERMUTE is exactly ROUNDS round_en cycles.
  - SQUEEZE is exactly ROUNDS round_en cycles.
- round_en and absorb_enable are never high in IDLE, CLEAR, LOAD_BUF, DUMP or DONE.
- last_output_block is not used for sequencing.

## Timing

- Reset:
  - State goes to IDLE, last_q=0.
  - All outputs are 0, including src_ready, dout_valid, busy, done and datapath_clear.
  - Reset applies mid-permutation or mid-dump with no completion pulse.
- src_ready and dout_valid are Moore outputs from state.
- absorb_enable, round_en, copy_control_regs_en and output_buffer_shift_en are combinational on the handshake inputs.
- Single-block message, src_valid already high in IDLE at cycle 0:
  - Cycle 1: CLEAR.
  - Cycle 2: absorb and round 0.
  - Cycles 3–25: PERMUTE.
  - Cycle 26: LOAD_BUF.
  - From cycle 27: first dout_valid.
- Each additional absorb block costs ROUNDS cycles plus any wait for src_valid.
- Each squeeze costs ROUNDS+1 cycles between the last shift and the next dout_valid.
- dout_valid stays high with data stable while dout_ready=0.
- src_valid dropping in ABSORB_FIRST or ABSORB_NEXT stalls the FSM indefinitely. No timeout.
- done follows the final transfer by exactly 1 cycle. busy drops the cycle after done.
- A new src_valid seen in IDLE the cycle after done starts the next message with no bubble beyond CLEAR.

## Test plan

- **Single SHAKE128 block, output 256 bits, W=64, dout_ready=1**
  - Required:
    - datapath_clear at cycle 1.
    - Absorb at cycle 2.
    - 24 round_en cycles, cycles 2–25.
    - output_buffer_we at cycle 26.
    - 4 dout_valid cycles, cycles 27–30.
    - done at cycle 31.
- **3-block SHAKE256 message, src_valid gapped by 5 idle cycles between blocks**
  - Required:
    - src_ready high during each gap.
    - Exactly 3 absorb_enable pulses, each coincident with round_en.
    - 72 round_en cycles in total.
    - copy_control_regs_en only on the first absorb.
- **SHAKE128 with 2000-bit output**
  - Required:
    - Buffer runs empty after 21 words, followed by a SQUEEZE of 24 rounds with absorb_enable=0.
    - A second LOAD_BUF follows.
    - The dump ends on output_size_reached after 32 words total.
    - One done pulse.
- **dout_ready toggling 1,0,0,1 during DUMP**
  - Required:
    - output_buffer_shift_en only in cycles where dout_ready=1.
    - dout_valid held high throughout.
    - No state change on stalled cycles.
- **Simultaneous output_buffer_empty and output_size_reached on a shift**
  - Required: go to DONE, with no SQUEEZE round_en.
- **rst asserted mid-PERMUTE (round 10) and mid-DUMP**
  - Required:
    - The next cycle is IDLE with all outputs 0.
    - No done pulse.
    - The next message runs the full CLEAR sequence.

Source files
------------

// File: rtl/permute_dump_control.sv
// Sequencing FSM for the Keccak permute/dump datapath: absorbs rate blocks,
// runs permutations, then loads and dumps the output buffer with squeezes.
module permute_dump_control #(
    parameter int ROUNDS = 24,
    parameter int W      = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic src_valid,
    input  logic src_last,
    output logic src_ready,
    output logic dout_valid,
    input  logic dout_ready,
    output logic busy,
    output logic done,
    output logic datapath_clear,
    output logic copy_control_regs_en,
    output logic absorb_enable,
    output logic round_en,
    output logic round_count_load,
    output logic output_buffer_we,
    output logic output_buffer_shift_en,
    output logic output_counter_load,
    output logic output_counter_rst,
    input  logic round_done,
    input  logic output_buffer_empty,
    input  logic last_output_block,
    input  logic output_size_reached
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_ABSORB_FIRST,
        S_PERMUTE,
        S_ABSORB_NEXT,
        S_LOAD_BUF,
        S_DUMP,
        S_SQUEEZE,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;

    // Moore outputs are registered from the next state so they line up with state_q.
    logic src_ready_q, src_ready_d;
    logic dout_valid_q, dout_valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic datapath_clear_q, datapath_clear_d;
    logic output_counter_rst_q, output_counter_rst_d;
    logic round_count_load_q, round_count_load_d;
    logic output_buffer_we_q, output_buffer_we_d;
    logic output_counter_load_q, output_counter_load_d;

    // Round count and word width live in the datapath; nothing here depends on them.
    logic unused_ok;
    assign unused_ok = &{1'b0, last_output_block, 1'(ROUNDS), 1'(W)};

    always_comb begin
        state_d                = state_q;
        last_d                 = last_q;
        copy_control_regs_en   = 1'b0;
        absorb_enable          = 1'b0;
        round_en               = 1'b0;
        output_buffer_shift_en = 1'b0;
        round_count_load       = round_count_load_q;

        case (state_q)
            S_IDLE: begin
                if (src_valid) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_ABSORB_FIRST;
            end
            S_ABSORB_FIRST: begin
                // Mode registers are copied in the same cycle as the first absorb.
                if (src_valid) begin
                    copy_control_regs_en = 1'b1;
                    absorb_enable        = 1'b1;
                    round_en             = 1'b1;
                    last_d               = src_last;
                    state_d              = S_PERMUTE;
                end
            end
            S_PERMUTE: begin
                round_en = 1'b1;
                if (round_done) begin
                    round_count_load = 1'b1;
                    state_d          = last_q ? S_LOAD_BUF : S_ABSORB_NEXT;
                end
            end
            S_ABSORB_NEXT: begin
                if (src_valid) begin
                    absorb_enable = 1'b1;
                    round_en      = 1'b1;
                    last_d        = src_last;
                    state_d       = S_PERMUTE;
                end
            end
            S_LOAD_BUF: begin
                state_d = S_DUMP;
            end
            S_DUMP: begin
                output_buffer_shift_en = dout_ready;
                if (dout_ready) begin
                    if (output_size_reached)      state_d = S_DONE;
                    else if (output_buffer_empty) state_d = S_SQUEEZE;
                end
            end
            S_SQUEEZE: begin
                round_en = 1'b1;
                if (round_done) begin
                    round_count_load = 1'b1;
                    state_d          = S_LOAD_BUF;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        src_ready_d           = (state_d == S_ABSORB_FIRST) || (state_d == S_ABSORB_NEXT);
        dout_valid_d          = (state_d == S_DUMP);
        busy_d                = (state_d != S_IDLE);
        done_d                = (state_d == S_DONE);
        datapath_clear_d      = (state_d == S_CLEAR);
        output_counter_rst_d  = (state_d == S_CLEAR);
        round_count_load_d    = (state_d == S_CLEAR);
        output_buffer_we_d    = (state_d == S_LOAD_BUF);
        output_counter_load_d = (state_d == S_LOAD_BUF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= S_IDLE;
            last_q                <= 1'b0;
            src_ready_q           <= 1'b0;
            dout_valid_q          <= 1'b0;
            busy_q                <= 1'b0;
            done_q                <= 1'b0;
            datapath_clear_q      <= 1'b0;
            output_counter_rst_q  <= 1'b0;
            round_count_load_q    <= 1'b0;
            output_buffer_we_q    <= 1'b0;
            output_counter_load_q <= 1'b0;
        end else begin
            state_q               <= state_d;
            last_q                <= last_d;
            src_ready_q           <= src_ready_d;
            dout_valid_q          <= dout_valid_d;
            busy_q                <= busy_d;
            done_q                <= done_d;
            datapath_clear_q      <= datapath_clear_d;
            output_counter_rst_q  <= output_counter_rst_d;
            round_count_load_q    <= round_count_load_d;
            output_buffer_we_q    <= output_buffer_we_d;
            output_counter_load_q <= output_counter_load_d;
        end
    end

    assign src_ready           = src_ready_q;
    assign dout_valid          = dout_valid_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign datapath_clear      = datapath_clear_q;
    assign output_counter_rst  = output_counter_rst_q;
    assign output_buffer_we    = output_buffer_we_q;
    assign output_counter_load = output_counter_load_q;

endmodule

// File: tb/tb_permute_dump_control.sv
// Directed bench for permute_dump_control with a small behavioural datapath
// supplying round_done / buffer-empty / size-reached status.
module tb_permute_dump_control;

    localparam int ROUNDS = 24;

    logic clk = 1'b0;
    logic rst, src_valid, src_last, dout_ready;
    logic src_ready, dout_valid, busy, done, datapath_clear;
    logic copy_control_regs_en, absorb_enable, round_en, round_count_load;
    logic output_buffer_we, output_buffer_shift_en, output_counter_load, output_counter_rst;
    logic round_done, output_buffer_empty, last_output_block, output_size_reached;

    always #5 clk = ~clk;

    permute_dump_control #(.ROUNDS(ROUNDS), .W(64)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done), .datapath_clear(datapath_clear),
        .copy_control_regs_en(copy_control_regs_en), .absorb_enable(absorb_enable),
        .round_en(round_en), .round_count_load(round_count_load),
        .output_buffer_we(output_buffer_we), .output_buffer_shift_en(output_buffer_shift_en),
        .output_counter_load(output_counter_load), .output_counter_rst(output_counter_rst),
        .round_done(round_done), .output_buffer_empty(output_buffer_empty),
        .last_output_block(last_output_block), .output_size_reached(output_size_reached)
    );

    // Behavioural datapath counters
    int rate_words = 21;
    int req_words  = 4;
    int rcnt, buf_left, out_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt     <= 0;
            buf_left <= 0;
            out_cnt  <= 0;
        end else begin
            if (round_count_load)  rcnt <= 0;
            else if (round_en)     rcnt <= rcnt + 1;
            if (output_buffer_we)            buf_left <= rate_words;
            else if (output_buffer_shift_en) buf_left <= buf_left - 1;
            if (output_counter_rst)          out_cnt <= 0;
            else if (output_buffer_shift_en) out_cnt <= out_cnt + 1;
        end
    end

    assign round_done          = (rcnt == ROUNDS - 1);
    assign output_buffer_empty = (buf_left == 1);
    assign output_size_reached = (out_cnt == req_words - 1);
    assign last_output_block   = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outvec();
        return int'({src_ready, dout_valid, busy, done, datapath_clear,
                     copy_control_regs_en, absorb_enable, round_en, round_count_load,
                     output_buffer_we, output_buffer_shift_en, output_counter_load,
                     output_counter_rst});
    endfunction

    // Per-run statistics
    int c_clear, n_clear, c_abs, n_abs, n_abs_bad, n_abs_after_we, n_copy, n_copy_bad;
    int n_round, first_round, last_round, n_round_after_we;
    int n_we, c_we, last_we, n_dv, first_dv, last_dv, n_stall_dv;
    int n_shift, n_shift_bad, c_empty_word, n_done, c_done, n_gap_ready;
    int busy_after_done, after_rst_vec, timed_out;

    task automatic run_msg(input int nblk, input int gap, input int rate, input int req,
                           input int rdy_pat, input int rst_at, input int maxcyc);
        int blocks_left, gapcnt, kdv;
        logic [3:0] pat;
        bit finished;
        pat = 4'b1001;
        rate_words = rate; req_words = req;
        c_clear = -1; n_clear = 0; c_abs = -1; n_abs = 0; n_abs_bad = 0; n_abs_after_we = 0;
        n_copy = 0; n_copy_bad = 0; n_round = 0; first_round = -1; last_round = -1;
        n_round_after_we = 0; n_we = 0; c_we = -1; last_we = -1; n_dv = 0; first_dv = -1;
        last_dv = -1; n_stall_dv = 0; n_shift = 0; n_shift_bad = 0; c_empty_word = -1;
        n_done = 0; c_done = -1; n_gap_ready = 0; busy_after_done = -1; after_rst_vec = -1;
        timed_out = 1; finished = 0;
        blocks_left = nblk; gapcnt = 0; kdv = 0;
        for (int cyc = 0; cyc <= maxcyc && !finished; cyc++) begin
            @(negedge clk);
            rst        = (cyc == rst_at);
            if (rst_at >= 0 && cyc >= rst_at) blocks_left = 0;
            src_valid  = (blocks_left > 0) && (gapcnt == 0);
            src_last   = (blocks_left == 1);
            dout_ready = (rdy_pat != 0) ? pat[kdv % 4] : 1'b1;
            #1;
            if (datapath_clear) begin n_clear++; if (c_clear < 0) c_clear = cyc; end
            if (absorb_enable) begin
                n_abs++;
                if (!round_en) n_abs_bad++;
                if (n_we > 0) n_abs_after_we++;
                if (c_abs < 0) c_abs = cyc;
            end
            if (copy_control_regs_en) begin
                n_copy++;
                if (!(absorb_enable && n_abs == 1)) n_copy_bad++;
            end
            if (round_en) begin
                n_round++;
                if (first_round < 0) first_round = cyc;
                last_round = cyc;
                if (n_we > 0) n_round_after_we++;
            end
            if (output_buffer_we) begin n_we++; last_we = cyc; if (c_we < 0) c_we = cyc; end
            if (dout_valid) begin
                n_dv++;
                if (first_dv < 0) first_dv = cyc;
                last_dv = cyc;
                if (!dout_ready) n_stall_dv++;
                kdv++;
            end
            if (output_buffer_shift_en) begin
                n_shift++;
                if (!dout_ready) n_shift_bad++;
                if (output_buffer_empty && !output_size_reached && c_empty_word < 0)
                    c_empty_word = n_shift;
            end
            if (done) begin n_done++; if (c_done < 0) c_done = cyc; end
            if (src_ready && !src_valid) n_gap_ready++;
            if (src_valid && src_ready) begin
                blocks_left--;
                gapcnt = gap;
            end else if (src_ready && !src_valid && gapcnt > 0) begin
                gapcnt--;
            end
            if (rst_at >= 0 && cyc == rst_at + 1) after_rst_vec = outvec();
            if (rst_at < 0 && c_done >= 0 && cyc == c_done + 1) begin
                busy_after_done = int'(busy);
                timed_out = 0; finished = 1;
            end
            if (rst_at >= 0 && cyc == rst_at + 8) begin
                timed_out = 0; finished = 1;
            end
        end
        rst = 1'b0; src_valid = 1'b0; src_last = 1'b0; dout_ready = 1'b1;
        chk("no_timeout", timed_out, 0);
    endtask

    initial begin
        rst = 1'b1; src_valid = 1'b1; src_last = 1'b1; dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", outvec(), 0);

        // Single SHAKE128 block, 4 words
        run_msg(1, 0, 21, 4, 0, -1, 200);
        chk("t1_clear_cycle", c_clear, 1);
        chk("t1_clear_count", n_clear, 1);
        chk("t1_absorb_cycle", c_abs, 2);
        chk("t1_absorb_count", n_abs, 1);
        chk("t1_copy_count", n_copy, 1);
        chk("t1_round_count", n_round, 24);
        chk("t1_first_round", first_round, 2);
        chk("t1_last_round", last_round, 25);
        chk("t1_we_cycle", c_we, 26);
        chk("t1_dv_count", n_dv, 4);
        chk("t1_first_dv", first_dv, 27);
        chk("t1_last_dv", last_dv, 30);
        chk("t1_done_cycle", c_done, 31);
        chk("t1_done_count", n_done, 1);
        chk("t1_busy_after_done", busy_after_done, 0);

        // 3-block SHAKE256 with 5-cycle gaps
        run_msg(3, 5, 17, 4, 0, -1, 400);
        chk("t2_gap_ready", n_gap_ready, 10);
        chk("t2_absorb_count", n_abs, 3);
        chk("t2_absorb_wo_round", n_abs_bad, 0);
        chk("t2_round_count", n_round, 72);
        chk("t2_copy_count", n_copy, 1);
        chk("t2_copy_misplaced", n_copy_bad, 0);
        chk("t2_we_cycle", c_we, 84);
        chk("t2_done_cycle", c_done, 89);

        // SHAKE128, 2000-bit output (32 words) with one squeeze
        run_msg(1, 0, 21, 32, 0, -1, 400);
        chk("t3_empty_word", c_empty_word, 21);
        chk("t3_squeeze_rounds", n_round_after_we, 24);
        chk("t3_squeeze_absorb", n_abs_after_we, 0);
        chk("t3_we_count", n_we, 2);
        chk("t3_second_we", last_we, 72);
        chk("t3_shift_count", n_shift, 32);
        chk("t3_done_count", n_done, 1);
        chk("t3_done_cycle", c_done, 84);

        // dout_ready pattern 1,0,0,1
        run_msg(1, 0, 21, 4, 1, -1, 200);
        chk("t4_shift_wo_ready", n_shift_bad, 0);
        chk("t4_shift_count", n_shift, 4);
        chk("t4_dv_count", n_dv, 8);
        chk("t4_dv_stalled", n_stall_dv, 4);
        chk("t4_last_dv", last_dv, 34);
        chk("t4_done_cycle", c_done, 35);

        // Buffer empty and size reached on the same shift
        run_msg(1, 0, 4, 4, 0, -1, 200);
        chk("t5_squeeze_rounds", n_round_after_we, 0);
        chk("t5_we_count", n_we, 1);
        chk("t5_done_cycle", c_done, 31);

        // Reset at round 10, then a clean message
        run_msg(1, 0, 21, 4, 0, 12, 200);
        chk("t6_rounds_before_rst", n_round, 11);
        chk("t6_outputs_after_rst", after_rst_vec, 0);
        chk("t6_no_done", n_done, 0);
        run_msg(1, 0, 21, 4, 0, -1, 200);
        chk("t6_clear_cycle", c_clear, 1);
        chk("t6_done_cycle", c_done, 31);

        // Reset mid-dump, then a clean message
        run_msg(1, 0, 21, 8, 0, 28, 200);
        chk("t7_dv_before_rst", n_dv, 2);
        chk("t7_outputs_after_rst", after_rst_vec, 0);
        chk("t7_no_done", n_done, 0);
        run_msg(1, 0, 21, 4, 0, -1, 200);
        chk("t7_clear_cycle", c_clear, 1);
        chk("t7_round_count", n_round, 24);
        chk("t7_done_cycle", c_done, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
